// File: rtl/alarm_ringer.sv
// Alarm event sequencer: ring, snooze, stop, timeout and re-arm.
// Drives the buzzer pattern and the alarm LEDs from registered state.
module alarm_ringer #(
   parameter int RING_SECONDS   = 60,
   parameter int SNOOZE_SECONDS = 300,
   parameter int MAX_SNOOZE     = 3,
   parameter int CNT_W          = 9
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   input  logic       alarm_match,
   input  logic       alarm_enable,
   input  logic       stop_imp,
   input  logic       snooze_imp,
   output logic       buzzer,
   output logic       ringing,
   output logic [3:0] ledsAl
);

   typedef enum logic [1:0] {
      IDLE,
      RINGING,
      SNOOZE,
      WAIT_CLEAR
   } state_t;

   localparam logic [CNT_W-1:0] RING_L = CNT_W'(RING_SECONDS);
   localparam logic [CNT_W-1:0] SNZ_L  = CNT_W'(SNOOZE_SECONDS);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
   localparam logic [1:0]       MAX_S  = 2'(MAX_SNOOZE);

   state_t           state, state_n;
   logic [CNT_W-1:0] counter, counter_n;
   logic [1:0]       snooze_cnt, snooze_cnt_n;
   logic             phase, phase_n;
   logic             match_d;
   logic             trigger;

   assign trigger = alarm_match & ~match_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         counter    <= '0;
         snooze_cnt <= '0;
         phase      <= 1'b0;
         match_d    <= 1'b1;
      end else begin
         state      <= state_n;
         counter    <= counter_n;
         snooze_cnt <= snooze_cnt_n;
         phase      <= phase_n;
         match_d    <= alarm_match;
      end
   end

   always_comb begin
      state_n      = state;
      counter_n    = counter;
      snooze_cnt_n = snooze_cnt;
      phase_n      = phase;
      if (state != IDLE && !alarm_enable) begin
         state_n      = IDLE;
         snooze_cnt_n = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (trigger && alarm_enable) begin
                  state_n   = RINGING;
                  counter_n = RING_L;
                  phase_n   = 1'b0;
               end
            end
            RINGING: begin
               if (tick_2hz) phase_n = ~phase;
               if (stop_imp) begin
                  state_n = WAIT_CLEAR;
               end else if (snooze_imp) begin
                  // Out of snoozes: the snooze button behaves as stop.
                  if (snooze_cnt < MAX_S) begin
                     state_n      = SNOOZE;
                     counter_n    = SNZ_L;
                     snooze_cnt_n = snooze_cnt + 2'd1;
                  end else begin
                     state_n = WAIT_CLEAR;
                  end
               end else if (tick_1hz) begin
                  if (counter == ONE) state_n = WAIT_CLEAR;
                  else counter_n = counter - ONE;
               end
            end
            SNOOZE: begin
               if (stop_imp) begin
                  state_n = WAIT_CLEAR;
               end else if (tick_1hz) begin
                  if (counter == ONE) begin
                     state_n   = RINGING;
                     counter_n = RING_L;
                     phase_n   = 1'b0;
                  end else begin
                     counter_n = counter - ONE;
                  end
               end
            end
            WAIT_CLEAR: begin
               if (!alarm_match) begin
                  state_n      = IDLE;
                  snooze_cnt_n = '0;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      ringing = (state == RINGING);
      buzzer  = (state == RINGING) & ~phase;
      ledsAl  = {snooze_cnt, state == SNOOZE, state == RINGING};
   end

endmodule

// File: tb/tb_alarm_ringer.sv
// Randomized scoreboard bench for alarm_ringer against an event-level model.
// Expected outputs are queued per cycle and checked by a separate monitor.
module tb_alarm_ringer;

   localparam int RING = 4;
   localparam int SNZ  = 3;
   localparam int MAXS = 2;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       tick_2hz = 1'b0;
   logic       alarm_match = 1'b0;
   logic       alarm_enable = 1'b0;
   logic       stop_imp = 1'b0;
   logic       snooze_imp = 1'b0;
   logic       buzzer;
   logic       ringing;
   logic [3:0] ledsAl;

   int n_cmp = 0;
   int n_bad = 0;

   alarm_ringer #(
      .RING_SECONDS(RING),
      .SNOOZE_SECONDS(SNZ),
      .MAX_SNOOZE(MAXS),
      .CNT_W(4)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .tick_1hz(tick_1hz),
      .tick_2hz(tick_2hz),
      .alarm_match(alarm_match),
      .alarm_enable(alarm_enable),
      .stop_imp(stop_imp),
      .snooze_imp(snooze_imp),
      .buzzer(buzzer),
      .ringing(ringing),
      .ledsAl(ledsAl)
   );

   always #5 clock = ~clock;

   // Reference model: alarm event described in seconds and half-seconds.
   // mode: 0 quiet, 1 ringing, 2 snoozing, 3 silenced until match clears.
   int mode;
   int secs_left;
   int halves;
   int snoozes_used;
   bit prev_match;

   typedef struct packed {
      logic       bz;
      logic       rg;
      logic [3:0] leds;
   } exp_t;

   exp_t q[$];

   function automatic void model_reset();
      mode = 0;
      secs_left = 0;
      halves = 0;
      snoozes_used = 0;
      prev_match = 1'b1;
   endfunction

   function automatic void model_step(bit t1, bit t2, bit m, bit en,
                                      bit st, bit sz);
      bit rise;
      rise = m && !prev_match;
      prev_match = m;
      if (mode == 0) begin
         if (rise && en) begin
            mode = 1;
            secs_left = RING;
            halves = 0;
         end
      end else if (!en) begin
         mode = 0;
         snoozes_used = 0;
      end else if (mode == 1) begin
         if (st) mode = 3;
         else if (sz) begin
            if (snoozes_used < MAXS) begin
               mode = 2;
               secs_left = SNZ;
               snoozes_used++;
            end else begin
               mode = 3;
            end
         end else begin
            if (t2) halves++;
            if (t1) begin
               if (secs_left == 1) mode = 3;
               else secs_left--;
            end
         end
      end else if (mode == 2) begin
         if (st) mode = 3;
         else if (t1) begin
            if (secs_left == 1) begin
               mode = 1;
               secs_left = RING;
               halves = 0;
            end else begin
               secs_left--;
            end
         end
      end else begin
         if (!m) begin
            mode = 0;
            snoozes_used = 0;
         end
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.rg = (mode == 1);
      e.bz = (mode == 1) && (halves % 2 == 0);
      e.leds = {2'(snoozes_used), mode == 2, mode == 1};
      return e;
   endfunction

   task automatic cyc(bit t1, bit t2, bit m, bit en, bit st, bit sz);
      @(negedge clock);
      tick_1hz = t1;
      tick_2hz = t2;
      alarm_match = m;
      alarm_enable = en;
      stop_imp = st;
      snooze_imp = sz;
      model_step(t1, t2, m, en, st, sz);
      q.push_back(model_out());
   endtask

   task automatic quiet(int n, bit m, bit en);
      for (int i = 0; i < n; i++) cyc(0, 0, m, en, 0, 0);
   endtask

   task automatic chk(string name, logic [5:0] got, logic [5:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("cycle", {buzzer, ringing, ledsAl}, {e.bz, e.rg, e.leds});
         end
      end
   end

   initial begin : stim
      bit m;
      bit en;
      model_reset();
      alarm_match = 1'b1;
      alarm_enable = 1'b1;
      #23;
      chk("reset_state", {buzzer, ringing, ledsAl}, 6'b0);
      @(negedge clock);
      reset_n = 1'b1;

      // match high through reset release: must not ring
      quiet(4, 1, 1);
      quiet(2, 0, 1);

      // timeout with buzzer pattern
      quiet(2, 1, 1);
      for (int s = 0; s < RING; s++) begin
         cyc(0, 1, 1, 1, 0, 0);
         quiet(1, 1, 1);
         cyc(0, 1, 1, 1, 0, 0);
         cyc(1, 0, 1, 1, 0, 0);
      end
      quiet(3, 1, 1);
      quiet(2, 0, 1);

      // snooze cycles then snooze limit acts as stop
      quiet(1, 1, 1);
      for (int k = 0; k < 3; k++) begin
         quiet(1, 1, 1);
         cyc(0, 0, 1, 1, 0, 1);
         for (int s = 0; s < SNZ; s++) begin
            quiet(1, 1, 1);
            cyc(1, 0, 1, 1, 0, 0);
         end
      end
      quiet(2, 1, 1);
      quiet(2, 0, 1);

      // stop and final tick together
      quiet(1, 1, 1);
      for (int s = 0; s < RING - 1; s++) cyc(1, 0, 1, 1, 0, 0);
      cyc(1, 0, 1, 1, 1, 0);
      quiet(2, 0, 1);

      // disarm while snoozing
      quiet(1, 1, 1);
      cyc(0, 0, 1, 1, 0, 1);
      quiet(1, 1, 1);
      quiet(2, 1, 0);
      quiet(2, 0, 1);

      // async reset while ringing
      quiet(2, 1, 1);
      @(posedge clock);
      #3;
      chk("pre_reset_ring", {buzzer, ringing}, 2'b11);
      reset_n = 1'b0;
      #1;
      chk("async_reset", {buzzer, ringing, ledsAl}, 6'b0);
      model_reset();
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      quiet(5, 1, 1);
      quiet(2, 0, 1);

      // randomized traffic
      m = 1'b0;
      en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 24) == 0) m = !m;
         if ($urandom_range(0, 99) == 0) en = !en;
         if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
         cyc($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, m, en,
             $urandom_range(0, 59) == 0, $urandom_range(0, 11) == 0);
      end

      @(posedge clock);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
